// File: rtl/fpu_rounder_if.sv
// Operand/result bus between the pre-round datapath, the rounder and the
// downstream normalizer. The master drives operands and out_ready; the
// slave (the rounder) returns in_ready and the rounded result.
interface fpu_rounder_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp;
  logic [26:0] in_man;
  logic [2:0]  rm;
  logic        out_ready;
  logic        rounded_result_sign;
  logic [8:0]  rounded_result_exp;
  logic [24:0] rounded_result_man;
  logic        round_flag;
  logic        inexact;
  logic        done_cal;

  modport master (
    output in_valid, in_sign, in_exp, in_man, rm, out_ready,
    input  in_ready, rounded_result_sign, rounded_result_exp,
           rounded_result_man, round_flag, inexact, done_cal
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_man, rm, out_ready,
    output in_ready, rounded_result_sign, rounded_result_exp,
           rounded_result_man, round_flag, inexact, done_cal
  );
endinterface

// File: rtl/fpu_rounder.sv
// fpu_rounder: 2-stage rounding pipeline for single-precision mantissas.
// S1 captures the accepted operand, S2 holds the rounded result until the
// normalizer takes it. The whole pipe freezes while S2 is full and blocked.
// Macro FPU_ROUND_MODE_EN: when defined, the rm input selects the rounding
// mode; otherwise every operand is rounded to nearest-even and rm is ignored.
module fpu_rounder (
  input  logic           clk,
  input  logic           rst_n,
  fpu_rounder_if.slave   bus
);
  localparam int STAGES = 2;
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  logic [STAGES:1] vld_pipe;
  logic            stall;
  logic            accept;

  logic            s1_sign;
  logic [8:0]      s1_exp;
  logic [26:0]     s1_man;
  logic [2:0]      rm_eff;

  logic            lsb, g, r, s, any;
  logic            inc;
  logic [24:0]     man_rnd;

  logic            s2_sign;
  logic [8:0]      s2_exp;
  logic [24:0]     s2_man;
  logic            s2_inexact;

  // A full, blocked S2 freezes both stages so nothing is lost or duplicated.
  assign stall       = vld_pipe[STAGES] & ~bus.out_ready;
  assign bus.in_ready = ~stall;
  assign accept      = bus.in_valid & ~stall;

  // Valid shift register: bit 1 = S1 occupied, bit 2 = S2 occupied.
  always_ff @(posedge clk) begin
    if (!rst_n)      vld_pipe <= '0;
    else if (!stall) vld_pipe <= {vld_pipe[1], accept};
  end

`ifdef FPU_ROUND_MODE_EN
  logic [2:0] s1_rm;

  // S1 operand capture, including the per-operand rounding mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_man  <= '0;
      s1_rm   <= RM_RNE;
    end else if (accept) begin
      s1_sign <= bus.in_sign;
      s1_exp  <= bus.in_exp;
      s1_man  <= bus.in_man;
      s1_rm   <= bus.rm;
    end
  end

  assign rm_eff = s1_rm;
`else
  logic unused_rm;
  assign unused_rm = ^bus.rm;

  // S1 operand capture; the mode is fixed so rm is not stored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_sign <= 1'b0;
      s1_exp  <= '0;
      s1_man  <= '0;
    end else if (accept) begin
      s1_sign <= bus.in_sign;
      s1_exp  <= bus.in_exp;
      s1_man  <= bus.in_man;
    end
  end

  assign rm_eff = RM_RNE;
`endif

  assign lsb = s1_man[3];
  assign g   = s1_man[2];
  assign r   = s1_man[1];
  assign s   = s1_man[0];
  assign any = g | r | s;

  // Increment decision; unused encodings fall back to nearest-even.
  always_comb begin
    inc = 1'b0;
    case (rm_eff)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = s1_sign & any;
      RM_RUP:  inc = ~s1_sign & any;
      RM_RMM:  inc = g;
      default: inc = g & (r | s | lsb);
    endcase
  end

  // Carry out of the 24-bit significand lands in bit 24 for the normalizer.
  assign man_rnd = {1'b0, s1_man[26:3]} + {24'd0, inc};

  // S2 result register; holds while stalled, refreshes only on a real operand.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_sign    <= 1'b0;
      s2_exp     <= '0;
      s2_man     <= '0;
      s2_inexact <= 1'b0;
    end else if (!stall && vld_pipe[1]) begin
      s2_sign    <= s1_sign;
      s2_exp     <= s1_exp;
      s2_man     <= man_rnd;
      s2_inexact <= any;
    end
  end

  assign bus.done_cal            = vld_pipe[STAGES];
  assign bus.round_flag          = vld_pipe[STAGES];
  assign bus.inexact             = vld_pipe[STAGES] & s2_inexact;
  assign bus.rounded_result_sign = s2_sign;
  assign bus.rounded_result_exp  = s2_exp;
  assign bus.rounded_result_man  = s2_man;
endmodule
